pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the MIPS core. It replaces the bare PC register with a self-contained fetch-address generator that owns next-PC selection, stall, exceptions and return, and halt/resume. Its boot sequence presents a reset vector and marks it valid one cycle after reset release. It sits between the control/branch logic and instruction memory, and also exports EPC and an advanced-instruction counter for debug.

## Interface
- WL, 32: address width; 8 ≤ WL ≤ 32.
- RESET_VEC, 32'h0000_0000: PC after reset, truncated to WL bits.
- EXC_VEC, 32'h0000_0180: exception handler address, truncated to WL bits.
- CNT_W, 32: width of the advanced-instruction counter.

- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- STALL  in  1  hold PC this cycle.
- BR_TAKEN  in  1  conditional branch resolved taken.
- BR_TGT  in  WL  branch target.
- JUMP  in  1  j/jal.
- J_TGT  in  WL  jump target.
- JR  in  1  jr/jalr.
- JR_TGT  in  WL  register jump target.
- EXC  in  1  synchronous exception request.
- ERET  in  1  return from exception.
- HALT  in  1  enter HALTED.
- RESUME  in  1  leave HALTED.
- PC_curr  out  WL  current fetch address.
- PC_plus4  out  WL  PC_curr + 4, combinational, wraps mod 2^WL.
- PC_valid  out  1  PC_curr is a fetchable address.
- EPC  out  WL  PC of the faulting instruction.
- MISALIGN  out  1  one-cycle pulse: a redirect target had nonzero bits [1:0].
- STATE  out  2  00 BOOT, 01 RUN, 10 HALTED.
- ADV_CNT  out  CNT_W  count of PC advances.

## Operation
- **Reset values:** PC_curr=RESET_VEC, EPC=0, ADV_CNT=0, MISALIGN=0, STATE=BOOT, PC_valid=0.
- **BOOT:** lasts exactly one cycle; PC is held and all inputs are ignored; the FSM always moves to RUN.
- **RUN, next-PC priority (highest first):**
  - EXC: PC←EXC_VEC, EPC←PC_curr.
  - ERET: PC←EPC.
  - JR: PC←JR_TGT.
  - JUMP: PC←J_TGT.
  - BR_TAKEN: PC←BR_TGT.
  - Otherwise: PC←PC_plus4.
- **Misaligned targets:**
  - A JR, JUMP or BR_TAKEN target with bits [1:0]≠0, when that source wins priority, is converted to an exception: PC←EXC_VEC, EPC←PC_curr, MISALIGN=1 for the next cycle.
  - An ERET to a misaligned EPC is not checked.
- **STALL (RUN):** PC, EPC and ADV_CNT hold, and all redirects except EXC are dropped. EXC overrides STALL.
- **HALT (RUN):** STATE←HALTED and the PC holds. HALT has priority over everything except EXC, which is taken the same cycle while the FSM still enters HALTED.
- **HALTED:** PC holds and PC_valid=0. RESUME→RUN with no PC change. Redirect inputs are ignored; EXC is ignored.
- **Simultaneous HALT and RESUME:**
  - In RUN, HALT wins.
  - In HALTED, RESUME wins.
- **ADV_CNT:** +1 on every edge where PC_curr changes value or is rewritten in RUN (including a redirect to the same address). It wraps at 2^CNT_W.
- **Reset mid-operation:** RST overrides all inputs on that edge, including EXC and HALT.

## Timing
- **Latency:** all redirects take effect one cycle after the edge sampling them; PC_curr is registered.
- **PC_valid:** combinational from STATE; 1 only in RUN.
- **MISALIGN:** registered, high for exactly one cycle per event.
- **PC_plus4:** valid the same cycle as PC_curr, no extra latency.
- **Wrap-around:** PC 0xFFFF_FFFC (WL=32) sequential → 0x0000_0000, no flag.

## Test plan
- **Reset, sequential run:** RST 2 cycles, then idle 4 cycles → STATE BOOT for 1 cycle; PC 0,0,4,8,0xC; ADV_CNT=3.
- **Stall and priority:** in RUN at PC=0x10, assert STALL+BR_TAKEN (BR_TGT=0x40) → PC holds 0x10. Next cycle BR_TAKEN+JUMP (J_TGT=0x80) → PC=0x80.
- **Exception and return:** EXC at PC=0x24 with STALL high → PC=0x180, EPC=0x24. ERET 3 cycles later → PC=0x24.
- **Misaligned jump register:** JR with JR_TGT=0x102 at PC=0x30 → PC=0x180, EPC=0x30, MISALIGN pulse of 1 cycle.
- **Halt and resume:** HALT at PC=0x50 → STATE=HALTED, PC_valid=0, PC holds 0x50 for 5 cycles despite JUMP. RESUME → RUN, next PC 0x54.
- **Counter wrap and reset:** CNT_W=4, 16 advances → ADV_CNT=0. RST asserted together with EXC → PC=RESET_VEC, EPC=0, STATE=BOOT.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit -- fetch-address generator for the MIPS core.
//
// Owns next-PC selection (exception, eret, jr, jump, branch, sequential),
// stall, halt/resume, a one-cycle boot state after reset, misaligned-target
// detection, the EPC register and an advanced-instruction counter.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   STALL               hold PC/EPC/ADV_CNT; only EXC gets through
//   BR_TAKEN/BR_TGT     taken conditional branch and its target
//   JUMP/J_TGT          j/jal and its target
//   JR/JR_TGT           jr/jalr and its register target
//   EXC, ERET           synchronous exception request, exception return
//   HALT, RESUME        enter / leave HALTED
//   PC_curr, PC_plus4   registered fetch address and its +4 (wrapping)
//   PC_valid            high only in RUN
//   EPC                 PC of the faulting instruction
//   MISALIGN            one-cycle pulse after a misaligned redirect
//   STATE               00 BOOT, 01 RUN, 10 HALTED
//   ADV_CNT             number of PC loads performed in RUN (wraps)
module pc_unit #(
  parameter int          WL        = 32,
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_0180,
  parameter int          CNT_W     = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             STALL,
  input  logic             BR_TAKEN,
  input  logic [WL-1:0]    BR_TGT,
  input  logic             JUMP,
  input  logic [WL-1:0]    J_TGT,
  input  logic             JR,
  input  logic [WL-1:0]    JR_TGT,
  input  logic             EXC,
  input  logic             ERET,
  input  logic             HALT,
  input  logic             RESUME,
  output logic [WL-1:0]    PC_curr,
  output logic [WL-1:0]    PC_plus4,
  output logic             PC_valid,
  output logic [WL-1:0]    EPC,
  output logic             MISALIGN,
  output logic [1:0]       STATE,
  output logic [CNT_W-1:0] ADV_CNT
);

  localparam logic [WL-1:0] RST_V = RESET_VEC[WL-1:0];
  localparam logic [WL-1:0] EXC_V = EXC_VEC[WL-1:0];

  typedef enum logic [1:0] {
    BOOT   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [WL-1:0]      pc_q, pc_d;
  logic [WL-1:0]      epc_q, epc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mis_q, mis_d;

  logic [WL-1:0]      pc_plus4;
  logic               tgt_sel;
  logic [WL-1:0]      tgt;

  assign pc_plus4 = pc_q + WL'(4);

  // Winning target among jr > jump > branch; eret is handled separately
  // because it bypasses the alignment check.
  always_comb begin
    tgt_sel = JR | JUMP | BR_TAKEN;
    if (JR)        tgt = JR_TGT;
    else if (JUMP) tgt = J_TGT;
    else           tgt = BR_TGT;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    cnt_d   = cnt_q;
    mis_d   = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (HALT) state_d = HALTED;
        // EXC beats both HALT and STALL; HALT still takes effect alongside.
        if (EXC) begin
          pc_d  = EXC_V;
          epc_d = pc_q;
          cnt_d = cnt_q + CNT_W'(1);
        end else if (!HALT && !STALL) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (ERET) begin
            pc_d = epc_q;
          end else if (tgt_sel) begin
            if (tgt[1:0] != 2'b00) begin
              // Misaligned redirect becomes an exception on this instruction.
              pc_d  = EXC_V;
              epc_d = pc_q;
              mis_d = 1'b1;
            end else begin
              pc_d = tgt;
            end
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      HALTED: if (RESUME) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= BOOT;
      pc_q    <= RST_V;
      epc_q   <= '0;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end

  assign PC_curr  = pc_q;
  assign PC_plus4 = pc_plus4;
  assign PC_valid = (state_q == RUN);
  assign EPC      = epc_q;
  assign MISALIGN = mis_q;
  assign STATE    = state_q;
  assign ADV_CNT  = cnt_q;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  logic        CLK = 1'b0;
  logic        RST, STALL, BR_TAKEN, JUMP, JR, EXC, ERET, HALT, RESUME;
  logic [31:0] BR_TGT, J_TGT, JR_TGT;

  logic [31:0] pc, pc4, epc, cnt;
  logic        valid, mis;
  logic [1:0]  st;

  logic [31:0] pc_b, pc4_b, epc_b;
  logic        valid_b, mis_b;
  logic [1:0]  st_b;
  logic [3:0]  cnt_b;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;

  always #5 CLK = ~CLK;

  pc_unit dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .BR_TAKEN(BR_TAKEN), .BR_TGT(BR_TGT),
    .JUMP(JUMP), .J_TGT(J_TGT), .JR(JR), .JR_TGT(JR_TGT), .EXC(EXC), .ERET(ERET),
    .HALT(HALT), .RESUME(RESUME), .PC_curr(pc), .PC_plus4(pc4), .PC_valid(valid),
    .EPC(epc), .MISALIGN(mis), .STATE(st), .ADV_CNT(cnt)
  );

  // Narrow-counter instance sharing the same stimulus, for the wrap check.
  pc_unit #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST), .STALL(STALL), .BR_TAKEN(BR_TAKEN), .BR_TGT(BR_TGT),
    .JUMP(JUMP), .J_TGT(J_TGT), .JR(JR), .JR_TGT(JR_TGT), .EXC(EXC), .ERET(ERET),
    .HALT(HALT), .RESUME(RESUME), .PC_curr(pc_b), .PC_plus4(pc4_b), .PC_valid(valid_b),
    .EPC(epc_b), .MISALIGN(mis_b), .STATE(st_b), .ADV_CNT(cnt_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference model: what the spec says happens on each rising edge.
  // Modes: 0 boot, 1 run, 2 halted.
  logic [31:0] m_pc, m_epc, m_cnt;
  logic [1:0]  m_st;
  logic        m_mis;

  always @(posedge CLK) begin : model
    logic [31:0] npc, nepc, ncnt, t;
    logic [1:0]  nst;
    logic        nmis, redirect, fault;
    npc = m_pc; nepc = m_epc; ncnt = m_cnt; nst = m_st; nmis = 1'b0;
    if (RST) begin
      npc = 32'h0; nepc = 32'h0; ncnt = 0; nst = 2'd0;
    end else if (m_st == 2'd0) begin
      nst = 2'd1;
    end else if (m_st == 2'd2) begin
      if (RESUME) nst = 2'd1;
    end else begin
      if (HALT) nst = 2'd2;
      fault = EXC;
      if (!EXC && !HALT && !STALL) begin
        redirect = 1'b1;
        if (ERET)          t = m_epc;
        else if (JR)       t = JR_TGT;
        else if (JUMP)     t = J_TGT;
        else if (BR_TAKEN) t = BR_TGT;
        else begin         t = m_pc + 32'd4; redirect = 1'b0; end
        if (!ERET && redirect && (t % 4 != 0)) begin
          fault = 1'b1; nmis = 1'b1;
        end else begin
          npc = t; ncnt = m_cnt + 1;
        end
      end
      if (fault) begin
        npc = 32'h180; nepc = m_pc; ncnt = m_cnt + 1;
      end
    end
    m_pc <= npc; m_epc <= nepc; m_cnt <= ncnt; m_st <= nst; m_mis <= nmis;
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("pc", pc, m_pc);
      chk("pc_plus4", pc4, m_pc + 32'd4);
      chk("pc_valid", {31'd0, valid}, {31'd0, m_st == 2'd1});
      chk("epc", epc, m_epc);
      chk("misalign", {31'd0, mis}, {31'd0, m_mis});
      chk("state", {30'd0, st}, {30'd0, m_st});
      chk("adv_cnt", cnt, m_cnt);
      chk("adv_cnt4", {28'd0, cnt_b}, {28'd0, m_cnt[3:0]});
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    STALL = 0; BR_TAKEN = 0; JUMP = 0; JR = 0; EXC = 0; ERET = 0; HALT = 0; RESUME = 0;
    BR_TGT = 0; J_TGT = 0; JR_TGT = 0;
  endtask

  initial begin
    idle();
    RST = 1;
    step(2);
    chk_en = 1;
    chk("rst pc", pc, 32'h0);
    chk("rst state", {30'd0, st}, 32'd0);
    chk("rst valid", {31'd0, valid}, 32'd0);
    chk("rst epc", epc, 32'h0);
    chk("rst cnt", cnt, 32'd0);
    RST = 0;
    // BOOT one cycle, then sequential.
    step(); chk("boot->run pc", pc, 32'h0); chk("run state", {30'd0, st}, 32'd1);
    step(); chk("seq pc 4", pc, 32'h4);
    step(); chk("seq pc 8", pc, 32'h8);
    step(); chk("seq pc C", pc, 32'hC); chk("seq cnt", cnt, 32'd3);
    step(); chk("seq pc 10", pc, 32'h10);
    // Stall drops the branch; then jump beats branch.
    STALL = 1; BR_TAKEN = 1; BR_TGT = 32'h40;
    step(); chk("stall hold", pc, 32'h10);
    STALL = 0; JUMP = 1; J_TGT = 32'h80;
    step(); chk("jump over br", pc, 32'h80);
    idle();
    // Stall also drops a misaligned jump without flagging it.
    STALL = 1; JUMP = 1; J_TGT = 32'h41;
    step(); chk("stall misalign drop", {31'd0, mis}, 32'd0);
    idle(); JR = 1; JR_TGT = 32'h24;
    step(); chk("jr pc", pc, 32'h24);
    // Exception overrides stall.
    idle(); EXC = 1; STALL = 1;
    step(); chk("exc pc", pc, 32'h180); chk("exc epc", epc, 32'h24);
    idle(); step(2);
    ERET = 1;
    step(); chk("eret pc", pc, 32'h24);
    idle(); JR = 1; JR_TGT = 32'h30;
    step();
    JR_TGT = 32'h102;
    step(); chk("misalign pc", pc, 32'h180); chk("misalign epc", epc, 32'h30);
    chk("misalign pulse", {31'd0, mis}, 32'd1);
    idle();
    step(); chk("misalign clears", {31'd0, mis}, 32'd0);
    // Misaligned branch too.
    BR_TAKEN = 1; BR_TGT = 32'h203;
    step(); chk("br misalign", {31'd0, mis}, 32'd1);
    idle(); JUMP = 1; J_TGT = 32'h50;
    step(); chk("jump 50", pc, 32'h50);
    idle(); HALT = 1;
    step(); chk("halt state", {30'd0, st}, 32'd2); chk("halt valid", {31'd0, valid}, 32'd0);
    idle(); JUMP = 1; J_TGT = 32'h90;
    for (int i = 0; i < 5; i++) begin
      EXC = (i == 2);
      step(); chk("halt hold", pc, 32'h50);
    end
    idle(); RESUME = 1; HALT = 1;
    step(); chk("resume wins", {30'd0, st}, 32'd1); chk("resume pc", pc, 32'h50);
    idle();
    step(); chk("after resume", pc, 32'h54);
    HALT = 1; RESUME = 1;
    step(); chk("halt wins", {30'd0, st}, 32'd2);
    idle(); RESUME = 1;
    step();
    idle(); HALT = 1; EXC = 1;
    step(); chk("halt+exc pc", pc, 32'h180); chk("halt+exc st", {30'd0, st}, 32'd2);
    chk("halt+exc epc", epc, 32'h54);
    idle(); RESUME = 1;
    step();
    // Wrap at top of address space.
    idle(); JR = 1; JR_TGT = 32'hFFFF_FFFC;
    step(); chk("plus4 wrap", pc4, 32'h0);
    idle();
    step(); chk("pc wrap", pc, 32'h0);
    // Reset wins over EXC and HALT.
    RST = 1; EXC = 1; HALT = 1;
    step(); chk("rst+exc pc", pc, 32'h0); chk("rst+exc epc", epc, 32'h0);
    chk("rst+exc st", {30'd0, st}, 32'd0);
    idle(); RST = 0;
    step();
    step(16); chk("cnt16", cnt, 32'd16); chk("cnt4 wrap", {28'd0, cnt_b}, 32'd0);
    step(); chk("cnt4 after", {28'd0, cnt_b}, 32'd1);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
